pipelined_word_adder: RTL

//  Parametrised, pipelined successor to the combinational word adder used by the integer datapath.

---
 rtl/pipelined_word_adder_pkg.sv | 33 +++
 rtl/pipelined_word_adder_slice.sv | 28 ++
 rtl/pipelined_word_adder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_word_adder_pkg.sv
// Shared definitions for the pipelined word adder.
//   ADDER_OP_W   width of the operation code
//   adder_op_e   ADD / ADC / SUB / SBC encodings
//   op_inverts_b true for operations that add the one's complement of B
//   op_carry_in  carry injected into the least significant slice
package pipelined_word_adder_pkg;

  localparam int unsigned ADDER_OP_W = 2;

  typedef enum logic [ADDER_OP_W-1:0] {
    ADDER_OP_ADD = 2'b00,
    ADDER_OP_ADC = 2'b01,
    ADDER_OP_SUB = 2'b10,
    ADDER_OP_SBC = 2'b11
  } adder_op_e;

  function automatic logic op_inverts_b(input adder_op_e op);
    return (op == ADDER_OP_SUB) || (op == ADDER_OP_SBC);
  endfunction

  // ADD forces 0, SUB forces 1 (two's complement), ADC/SBC use the caller's carry.
  function automatic logic op_carry_in(input adder_op_e op, input logic cin);
    logic c;
    case (op)
      ADDER_OP_ADD: c = 1'b0;
      ADDER_OP_ADC: c = cin;
      ADDER_OP_SUB: c = 1'b1;
      default:      c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipelined_word_adder_slice.sv
// One carry-chain slice of the pipelined word adder.
//   a, b  : SLICE_W-bit operand slices (b already inverted for subtraction)
//   cin   : carry into the slice LSB
//   sum   : SLICE_W-bit slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (XOR with cout gives signed overflow)
module pipelined_word_adder_slice #(
  parameter int unsigned SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               cmsb
);

  logic [SLICE_W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    sum  = full[SLICE_W-1:0];
    cout = full[SLICE_W];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of an XOR.
    cmsb = sum[SLICE_W-1] ^ a[SLICE_W-1] ^ b[SLICE_W-1];
  end

endmodule

// File: rtl/pipelined_word_adder.sv
// Pipelined ADD/ADC/SUB/SBC unit with ARM-style N/Z/C/V flags.
// The WIDTH-bit carry chain is cut into STAGES slices, one slice per register
// stage; latency is STAGES cycles and throughput one operation per cycle.
// Optional build macro: ADDER_SATURATE_EN (clamp result on signed overflow).
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   in_Flush                     kill every in-flight operation (synchronous)
//   in_Valid / out_Ready         operand handshake
//   in_Op                        00 ADD, 01 ADC, 10 SUB, 11 SBC
//   in_LeftOperand/RightOperand  A and B
//   in_LowCarry                  carry-in for ADC/SBC
//   out_Valid / in_Ready         result handshake
//   out_Result                   sum (clamped when saturation is built in)
//   out_Carry/Zero/Neg/Overflow  C Z N V flags
//   out_Sat                      saturation happened (0 unless ADDER_SATURATE_EN)
module pipelined_word_adder
  import pipelined_word_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_Flush,
  input  logic                  in_Valid,
  output logic                  out_Ready,
  input  logic [ADDER_OP_W-1:0] in_Op,
  input  logic [WIDTH-1:0]      in_LeftOperand,
  input  logic [WIDTH-1:0]      in_RightOperand,
  input  logic                  in_LowCarry,
  output logic                  out_Valid,
  input  logic                  in_Ready,
  output logic [WIDTH-1:0]      out_Result,
  output logic                  out_Carry,
  output logic                  out_Zero,
  output logic                  out_Neg,
  output logic                  out_Overflow,
  output logic                  out_Sat
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_word_adder: STAGES must be 1..4 and divide WIDTH");
  end

  // Stage registers. sum_q[k] holds result bits [0 .. (k+1)*SW-1]; a_q/b_q carry
  // the not-yet-added upper operand slices forward.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic              cmsb_q;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];

  logic [STAGES-1:0] load_en;
  logic [STAGES-1:0] stg_v;
  logic [WIDTH-1:0]  stg_a   [STAGES];
  logic [WIDTH-1:0]  stg_b   [STAGES];
  logic [WIDTH-1:0]  stg_sum [STAGES];

  logic [WIDTH-1:0]  slice_a;
  logic [WIDTH-1:0]  slice_b;
  logic [WIDTH-1:0]  slice_sum;
  logic [STAGES-1:0] slice_cin;
  logic [STAGES-1:0] slice_cout;
  logic              fin_cmsb;

  adder_op_e         op;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

  logic [WIDTH-1:0]  fin_res;
  logic              fin_ovf;
  logic              fin_sat;

  // A stage may load when it is empty or its content moves on this cycle.
  // Walking from the output backwards lets bubbles collapse.
  always_comb begin
    logic down_ok;
    down_ok = in_Ready;
    load_en = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      load_en[LAST-i] = ~valid_q[LAST-i] | down_ok;
      down_ok         = load_en[LAST-i];
    end
  end

  assign out_Ready = ~in_Flush & load_en[0];

  // Operand conditioning and per-stage inputs.
  always_comb begin
    op        = adder_op_e'(in_Op);
    b_eff     = op_inverts_b(op) ? ~in_RightOperand : in_RightOperand;
    cin_eff   = op_carry_in(op, in_LowCarry);
    stg_v[0]  = in_Valid & ~in_Flush;
    stg_a[0]  = in_LeftOperand;
    stg_b[0]  = b_eff;
    slice_cin = '0;
    slice_cin[0] = cin_eff;
    for (int unsigned k = 1; k < STAGES; k++) begin
      stg_v[k]     = valid_q[k-1];
      stg_a[k]     = a_q[k-1];
      stg_b[k]     = b_q[k-1];
      slice_cin[k] = carry_q[k-1];
    end
    slice_a = '0;
    slice_b = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      slice_a[k*SW +: SW] = stg_a[k][k*SW +: SW];
      slice_b[k*SW +: SW] = stg_b[k][k*SW +: SW];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == LAST) begin : g_last
      pipelined_word_adder_slice #(.SLICE_W(SW)) u_slice (
        .a    (slice_a[k*SW +: SW]),
        .b    (slice_b[k*SW +: SW]),
        .cin  (slice_cin[k]),
        .sum  (slice_sum[k*SW +: SW]),
        .cout (slice_cout[k]),
        .cmsb (fin_cmsb)
      );
    end else begin : g_mid
      logic cmsb_unused;
      pipelined_word_adder_slice #(.SLICE_W(SW)) u_slice (
        .a    (slice_a[k*SW +: SW]),
        .b    (slice_b[k*SW +: SW]),
        .cin  (slice_cin[k]),
        .sum  (slice_sum[k*SW +: SW]),
        .cout (slice_cout[k]),
        .cmsb (cmsb_unused)
      );
    end
  end

  // Merge the freshly added slice into the partial result handed forward.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      stg_sum[k] = '0;
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      stg_sum[k] = sum_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      stg_sum[k][k*SW +: SW] = slice_sum[k*SW +: SW];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      carry_q <= '0;
      cmsb_q  <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (in_Flush) begin
          valid_q[k] <= 1'b0;
        end else if (load_en[k]) begin
          valid_q[k] <= stg_v[k];
          if (stg_v[k]) begin
            sum_q[k]   <= stg_sum[k];
            a_q[k]     <= stg_a[k];
            b_q[k]     <= stg_b[k];
            carry_q[k] <= slice_cout[k];
            if (k == LAST) begin
              cmsb_q <= fin_cmsb;
            end
          end
        end
      end
    end
  end

  // Flags come only from the final stage and are masked until out_Valid.
  always_comb begin
    fin_res = sum_q[LAST];
    fin_ovf = carry_q[LAST] ^ cmsb_q;
    fin_sat = 1'b0;
`ifdef ADDER_SATURATE_EN
    // A wrapped negative result means the true value overflowed positive.
    if (fin_ovf) begin
      fin_res = sum_q[LAST][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
      fin_sat = 1'b1;
    end
`endif
    out_Valid    = valid_q[LAST];
    out_Result   = out_Valid ? fin_res : '0;
    out_Carry    = out_Valid & carry_q[LAST];
    out_Overflow = out_Valid & fin_ovf;
    out_Neg      = out_Valid & fin_res[WIDTH-1];
    out_Zero     = out_Valid & (fin_res == '0);
    out_Sat      = out_Valid & fin_sat;
  end

endmodule
